// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of one register port between N_REQ requesters.
// Ports:
//   ipClk, ipReset           clock (rising edge), asynchronous active-low reset
//   ipReqValid/Write         per-requester request and direction (1 = write)
//   ipReqAddress/WrData      packed per-requester address and write data
//   opReqReady               one-cycle accept pulse to the granted requester
//   opRspValid, opRspData    one-cycle read-response pulse and shared read data
//   opAddress/WrData/WrEnable  drive the Registers block
//   ipRdData                 registered read data from the Registers block
//   opBusy                   high whenever a transaction is in flight
module reg_bus_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                     ipClk,
    input  logic                     ipReset,
    input  logic [N_REQ-1:0]         ipReqValid,
    input  logic [N_REQ-1:0]         ipReqWrite,
    input  logic [N_REQ*ADDR_W-1:0]  ipReqAddress,
    input  logic [N_REQ*DATA_W-1:0]  ipReqWrData,
    output logic [N_REQ-1:0]         opReqReady,
    output logic [N_REQ-1:0]         opRspValid,
    output logic [DATA_W-1:0]        opRspData,
    output logic [ADDR_W-1:0]        opAddress,
    output logic [DATA_W-1:0]        opWrData,
    output logic                     opWrEnable,
    input  logic [DATA_W-1:0]        ipRdData,
    output logic                     opBusy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q;
    logic [PW-1:0]       ptr_q, gnt_q, gnt_d, ptr_d, idx;
    logic                wr_q, busy_q, we_q, hit;
    logic [N_REQ-1:0]    ready_q, rspv_q;
    logic [DATA_W-1:0]   rsp_q, wd_q;
    logic [ADDR_W-1:0]   addr_q;

    // First valid requester at or above the pointer, wrapping to 0.
    always_comb begin
        gnt_d = ptr_q;
        hit   = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (!hit && ipReqValid[idx]) begin
                gnt_d = idx;
                hit   = 1'b1;
            end
        end
        ptr_d = PW'((int'(gnt_d) + 1) % N_REQ);
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= '0;
            rspv_q  <= '0;
            rsp_q   <= '0;
            wd_q    <= '0;
            addr_q  <= '0;
        end else begin
            ready_q <= '0;
            rspv_q  <= '0;
            we_q    <= 1'b0;
            case (state_q)
                IDLE: if (|ipReqValid) begin
                    ready_q[gnt_d] <= 1'b1;
                    addr_q  <= ipReqAddress[int'(gnt_d)*ADDR_W +: ADDR_W];
                    wd_q    <= ipReqWrData[int'(gnt_d)*DATA_W +: DATA_W];
                    we_q    <= ipReqWrite[gnt_d];
                    wr_q    <= ipReqWrite[gnt_d];
                    gnt_q   <= gnt_d;
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    busy_q  <= !wr_q;
                    state_q <= wr_q ? IDLE : WAIT;
                end
                WAIT: begin
                    rsp_q         <= ipRdData;
                    rspv_q[gnt_q] <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign opReqReady = ready_q;
    assign opRspValid = rspv_q;
    assign opRspData  = rsp_q;
    assign opAddress  = addr_q;
    assign opWrData   = wd_q;
    assign opWrEnable = we_q;
    assign opBusy     = busy_q;
endmodule
